// File: rtl/mfs_req_arbiter.sv
// Round-robin arbiter sharing one slave request/response channel among N_MASTERS masters.
// Optional build macro MFS_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module mfs_req_arbiter #(
    parameter int N_MASTERS       = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_MASTERS-1:0]         m_req_cmd,
    input  logic [N_MASTERS-1:0][26:0]   m_req_addr,
    input  logic [N_MASTERS-1:0][127:0]  m_req_data,
    input  logic [N_MASTERS-1:0]         m_req_en,
    output logic [N_MASTERS-1:0]         m_req_rdy,
    output logic [127:0]                 m_rsp_data,
    output logic [N_MASTERS-1:0]         m_rsp_en,
    input  logic [N_MASTERS-1:0]         m_rsp_rdy,
    output logic                         s_req_cmd,
    output logic [26:0]                  s_req_addr,
    output logic [127:0]                 s_req_data,
    output logic                         s_req_en,
    input  logic                         s_req_rdy,
    input  logic [127:0]                 s_rsp_data,
    input  logic                         s_rsp_en,
    output logic                         s_rsp_rdy,
    output logic                         err_unexp_rsp
);

    localparam int ID_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic                 r_s_req_en;
    logic                 r_s_req_cmd;
    logic [26:0]          r_s_req_addr;
    logic [127:0]         r_s_req_data;
    logic [ID_W-1:0]      r_tag [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_err;

    logic [N_MASTERS-1:0] w_elig;
    logic [ID_W-1:0]      w_start;
    logic [ID_W-1:0]      w_winner;
    logic                 w_found;
    logic                 w_slot_free;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [ID_W-1:0]      w_head;

    assign w_full      = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_empty     = (r_count == '0);
    assign w_head      = r_tag[r_rd_ptr];
    assign w_slot_free = !r_s_req_en || s_req_rdy;

`ifdef MFS_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [ID_W-1:0] r_rr;
    logic [ID_W-1:0] w_rr_next;

    assign w_start   = r_rr;
    assign w_rr_next = (w_winner == ID_W'(N_MASTERS - 1)) ? '0 : w_winner + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= '0;
        end else if (w_accept) begin
            r_rr <= w_rr_next;
        end
    end
`endif

    // Reads are held off while every tag slot is in use; writes never wait on the FIFO.
    always_comb begin
        w_elig   = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_elig[i] = m_req_en[i] && (!m_req_cmd[i] || !w_full);
        end
        for (int k = 0; k < N_MASTERS; k++) begin
            int idx;
            idx = int'(w_start) + k;
            if (idx >= N_MASTERS) idx = idx - N_MASTERS;
            if (!w_found && w_elig[idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(idx);
            end
        end
    end

    assign w_accept = w_found && w_slot_free && rst_n;
    assign w_push   = w_accept && m_req_cmd[w_winner];
    assign w_pop    = s_rsp_en && s_rsp_rdy && !w_empty;

    always_comb begin
        m_req_rdy = '0;
        if (w_accept) m_req_rdy[w_winner] = 1'b1;
    end

    // With no read outstanding the response is swallowed so the slave never stalls.
    always_comb begin
        m_rsp_en  = '0;
        s_rsp_rdy = 1'b1;
        if (!w_empty) begin
            m_rsp_en[w_head] = s_rsp_en;
            s_rsp_rdy        = m_rsp_rdy[w_head];
        end
    end

    assign m_rsp_data = s_rsp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_req_en   <= 1'b0;
            r_s_req_cmd  <= 1'b0;
            r_s_req_addr <= '0;
            r_s_req_data <= '0;
        end else if (w_accept) begin
            r_s_req_en   <= 1'b1;
            r_s_req_cmd  <= m_req_cmd[w_winner];
            r_s_req_addr <= m_req_addr[w_winner];
            r_s_req_data <= m_req_data[w_winner];
        end else if (s_req_rdy) begin
            r_s_req_en   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_tag[r_wr_ptr] <= w_winner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (s_rsp_en && w_empty) r_err <= 1'b1;
        end
    end

    assign s_req_en      = r_s_req_en;
    assign s_req_cmd     = r_s_req_cmd;
    assign s_req_addr    = r_s_req_addr;
    assign s_req_data    = r_s_req_data;
    assign err_unexp_rsp = r_err;

endmodule

// File: tb/tb_mfs_req_arbiter.sv
// Directed table-driven bench for mfs_req_arbiter with two masters and four tags.
module tb_mfs_req_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        m_req_cmd;
    logic [1:0][26:0]  m_req_addr;
    logic [1:0][127:0] m_req_data;
    logic [1:0]        m_req_en;
    logic [1:0]        m_req_rdy;
    logic [127:0]      m_rsp_data;
    logic [1:0]        m_rsp_en;
    logic [1:0]        m_rsp_rdy;
    logic              s_req_cmd;
    logic [26:0]       s_req_addr;
    logic [127:0]      s_req_data;
    logic              s_req_en;
    logic              s_req_rdy;
    logic [127:0]      s_rsp_data;
    logic              s_rsp_en;
    logic              s_rsp_rdy;
    logic              err_unexp_rsp;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mfs_req_arbiter #(.N_MASTERS(2), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_cmd(m_req_cmd), .m_req_addr(m_req_addr), .m_req_data(m_req_data),
        .m_req_en(m_req_en), .m_req_rdy(m_req_rdy),
        .m_rsp_data(m_rsp_data), .m_rsp_en(m_rsp_en), .m_rsp_rdy(m_rsp_rdy),
        .s_req_cmd(s_req_cmd), .s_req_addr(s_req_addr), .s_req_data(s_req_data),
        .s_req_en(s_req_en), .s_req_rdy(s_req_rdy),
        .s_rsp_data(s_rsp_data), .s_rsp_en(s_rsp_en), .s_rsp_rdy(s_rsp_rdy),
        .err_unexp_rsp(err_unexp_rsp)
    );

    typedef struct {
        logic [1:0]  en;
        logic [1:0]  cmd;
        logic [26:0] a0;
        logic [26:0] a1;
        logic        srdy;
        logic        rspen;
        logic [7:0]  rspd;
        logic [1:0]  mrr;
        logic [1:0]  e_rdy;
        logic        e_sen;
        logic [26:0] e_addr;
        logic        e_cmd;
        logic [7:0]  e_lo;
        logic [1:0]  e_rspen;
        logic        e_srr;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic [1:0] en, input logic [1:0] cmd, input logic [26:0] a0, input logic [26:0] a1,
        input logic srdy, input logic rspen, input logic [7:0] rspd, input logic [1:0] mrr,
        input logic [1:0] e_rdy, input logic e_sen, input logic [26:0] e_addr, input logic e_cmd,
        input logic [7:0] e_lo, input logic [1:0] e_rspen, input logic e_srr, input logic e_err);
        vec_t v;
        v.en = en; v.cmd = cmd; v.a0 = a0; v.a1 = a1; v.srdy = srdy; v.rspen = rspen;
        v.rspd = rspd; v.mrr = mrr; v.e_rdy = e_rdy; v.e_sen = e_sen; v.e_addr = e_addr;
        v.e_cmd = e_cmd; v.e_lo = e_lo; v.e_rspen = e_rspen; v.e_srr = e_srr; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply_and_check(input int idx, input vec_t v);
        m_req_en      = v.en;
        m_req_cmd     = v.cmd;
        m_req_addr[0] = v.a0;
        m_req_addr[1] = v.a1;
        s_req_rdy     = v.srdy;
        s_rsp_en      = v.rspen;
        s_rsp_data    = {120'b0, v.rspd};
        m_rsp_rdy     = v.mrr;
        #1;
        chk($sformatf("v%0d m_req_rdy", idx),  128'(m_req_rdy),     128'(v.e_rdy));
        chk($sformatf("v%0d s_req_en", idx),   128'(s_req_en),      128'(v.e_sen));
        chk($sformatf("v%0d s_req_addr", idx), 128'(s_req_addr),    128'(v.e_addr));
        chk($sformatf("v%0d s_req_cmd", idx),  128'(s_req_cmd),     128'(v.e_cmd));
        chk($sformatf("v%0d s_req_data", idx), s_req_data,          {16{v.e_lo}});
        chk($sformatf("v%0d m_rsp_en", idx),   128'(m_rsp_en),      128'(v.e_rspen));
        chk($sformatf("v%0d m_rsp_data", idx), m_rsp_data,          {120'b0, v.rspd});
        chk($sformatf("v%0d s_rsp_rdy", idx),  128'(s_rsp_rdy),     128'(v.e_srr));
        chk($sformatf("v%0d err", idx),        128'(err_unexp_rsp), 128'(v.e_err));
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        m_req_en      = 2'b00;
        m_req_cmd     = 2'b00;
        m_req_addr[0] = '0;
        m_req_addr[1] = '0;
        m_req_data[0] = {16{8'hA5}};
        m_req_data[1] = {16{8'h5A}};
        m_rsp_rdy     = 2'b00;
        s_req_rdy     = 1'b0;
        s_rsp_en      = 1'b0;
        s_rsp_data    = '0;

`ifndef MFS_ARB_FIXED_PRIO_EN
        // en  cmd   a0      a1      srdy rspen rspd   mrr  | rdy  sen addr    cmd lo     rspen srr err
        vq.push_back(mk(2'b01, 2'b00, 27'h010, 27'h000, 1, 0, 8'h00, 2'b00, 2'b01, 0, 27'h000, 0, 8'h00, 2'b00, 1, 0));
        vq.push_back(mk(2'b00, 2'b00, 27'h010, 27'h000, 1, 0, 8'h00, 2'b00, 2'b00, 1, 27'h010, 0, 8'hA5, 2'b00, 1, 0));
        vq.push_back(mk(2'b11, 2'b11, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b10, 0, 27'h010, 0, 8'hA5, 2'b00, 1, 0));
        vq.push_back(mk(2'b11, 2'b11, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b01, 1, 27'h200, 1, 8'h5A, 2'b00, 0, 0));
        vq.push_back(mk(2'b11, 2'b11, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b10, 1, 27'h100, 1, 8'hA5, 2'b00, 0, 0));
        vq.push_back(mk(2'b11, 2'b11, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b01, 1, 27'h200, 1, 8'h5A, 2'b00, 0, 0));
        // Tags full: M1 read blocked, M0 write still accepted.
        vq.push_back(mk(2'b11, 2'b10, 27'h300, 27'h200, 1, 0, 8'h00, 2'b00, 2'b01, 1, 27'h100, 1, 8'hA5, 2'b00, 0, 0));
        vq.push_back(mk(2'b10, 2'b10, 27'h300, 27'h200, 1, 1, 8'h11, 2'b11, 2'b00, 1, 27'h300, 0, 8'hA5, 2'b10, 1, 0));
        vq.push_back(mk(2'b10, 2'b10, 27'h300, 27'h200, 1, 0, 8'h00, 2'b11, 2'b10, 0, 27'h300, 0, 8'hA5, 2'b00, 1, 0));
        // Responses return in issue order: M0, M1, M0 (stalled 3 cycles), M1.
        vq.push_back(mk(2'b00, 2'b00, 27'h300, 27'h200, 1, 1, 8'h01, 2'b11, 2'b00, 1, 27'h200, 1, 8'h5A, 2'b01, 1, 0));
        vq.push_back(mk(2'b00, 2'b00, 27'h300, 27'h200, 1, 1, 8'h02, 2'b11, 2'b00, 0, 27'h200, 1, 8'h5A, 2'b10, 1, 0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(2'b00, 2'b00, 27'h300, 27'h200, 1, 1, 8'h03, 2'b10, 2'b00, 0, 27'h200, 1, 8'h5A, 2'b01, 0, 0));
        vq.push_back(mk(2'b00, 2'b00, 27'h300, 27'h200, 1, 1, 8'h03, 2'b11, 2'b00, 0, 27'h200, 1, 8'h5A, 2'b01, 1, 0));
        vq.push_back(mk(2'b00, 2'b00, 27'h300, 27'h200, 1, 1, 8'h04, 2'b11, 2'b00, 0, 27'h200, 1, 8'h5A, 2'b10, 1, 0));
        vq.push_back(mk(2'b00, 2'b00, 27'h300, 27'h200, 1, 0, 8'h00, 2'b11, 2'b00, 0, 27'h200, 1, 8'h5A, 2'b00, 1, 0));
        // Slave back-pressure: slot holds while s_req_rdy=0.
        vq.push_back(mk(2'b10, 2'b00, 27'h300, 27'h400, 0, 0, 8'h00, 2'b00, 2'b10, 0, 27'h200, 1, 8'h5A, 2'b00, 1, 0));
        vq.push_back(mk(2'b01, 2'b00, 27'h500, 27'h400, 0, 0, 8'h00, 2'b00, 2'b00, 1, 27'h400, 0, 8'h5A, 2'b00, 1, 0));
        vq.push_back(mk(2'b01, 2'b00, 27'h500, 27'h400, 1, 0, 8'h00, 2'b00, 2'b01, 1, 27'h400, 0, 8'h5A, 2'b00, 1, 0));
        vq.push_back(mk(2'b00, 2'b00, 27'h500, 27'h400, 1, 0, 8'h00, 2'b00, 2'b00, 1, 27'h500, 0, 8'hA5, 2'b00, 1, 0));
        // Unexpected response while idle.
        vq.push_back(mk(2'b00, 2'b00, 27'h500, 27'h400, 1, 1, 8'h05, 2'b00, 2'b00, 0, 27'h500, 0, 8'hA5, 2'b00, 1, 0));
        vq.push_back(mk(2'b00, 2'b00, 27'h500, 27'h400, 1, 0, 8'h00, 2'b00, 2'b00, 0, 27'h500, 0, 8'hA5, 2'b00, 1, 1));
        vq.push_back(mk(2'b00, 2'b00, 27'h500, 27'h400, 1, 0, 8'h00, 2'b00, 2'b00, 0, 27'h500, 0, 8'hA5, 2'b00, 1, 1));
`else
        // Fixed priority: M0 wins every cycle while it requests.
        vq.push_back(mk(2'b11, 2'b11, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b01, 0, 27'h000, 0, 8'h00, 2'b00, 1, 0));
        vq.push_back(mk(2'b11, 2'b11, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b01, 1, 27'h100, 1, 8'hA5, 2'b00, 0, 0));
        vq.push_back(mk(2'b11, 2'b11, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b01, 1, 27'h100, 1, 8'hA5, 2'b00, 0, 0));
        vq.push_back(mk(2'b11, 2'b11, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b01, 1, 27'h100, 1, 8'hA5, 2'b00, 0, 0));
        vq.push_back(mk(2'b11, 2'b11, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b00, 1, 27'h100, 1, 8'hA5, 2'b00, 0, 0));
        vq.push_back(mk(2'b10, 2'b10, 27'h100, 27'h200, 1, 1, 8'h07, 2'b01, 2'b00, 0, 27'h100, 1, 8'hA5, 2'b01, 1, 0));
        vq.push_back(mk(2'b10, 2'b10, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b10, 0, 27'h100, 1, 8'hA5, 2'b00, 0, 0));
        vq.push_back(mk(2'b00, 2'b00, 27'h100, 27'h200, 1, 0, 8'h00, 2'b00, 2'b00, 1, 27'h200, 1, 8'h5A, 2'b00, 0, 0));
`endif

        // Reset state, including m_req_rdy held low while a master requests.
        @(negedge clk);
        m_req_en = 2'b01;
        #1;
        chk("reset m_req_rdy", 128'(m_req_rdy), 128'(2'b00));
        chk("reset s_req_en",  128'(s_req_en), 128'(1'b0));
        chk("reset s_req_addr", 128'(s_req_addr), 128'(27'h0));
        chk("reset err", 128'(err_unexp_rsp), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) apply_and_check(i, vq[i]);

        // Mid-operation reset clears the sticky error and the slot asynchronously.
        m_req_en  = 2'b11;
        m_req_cmd = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset m_req_rdy", 128'(m_req_rdy), 128'(2'b00));
        chk("midreset s_req_en", 128'(s_req_en), 128'(1'b0));
        chk("midreset s_req_addr", 128'(s_req_addr), 128'(27'h0));
        chk("midreset err", 128'(err_unexp_rsp), 128'(1'b0));
        chk("midreset m_rsp_en", 128'(m_rsp_en), 128'(2'b00));
        @(negedge clk);
        rst_n    = 1'b1;
        m_req_en = 2'b00;
        @(negedge clk);
        #1;
        chk("postreset err", 128'(err_unexp_rsp), 128'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
